// File: rtl/vga_slave_rx.sv
// Receiver for a scrambled VGA-style pixel stream: recovers h/v position from the syncs,
// validates the frame timing before asserting lock, and XOR-descrambles pixels with an LFSR keystream.
module vga_slave_rx #(
  parameter int          H_TOTAL       = 800,
  parameter int          V_TOTAL       = 525,
  parameter int          H_ACT_START   = 144,
  parameter int          V_ACT_START   = 35,
  parameter logic [11:0] KEY_ZERO_SEED = 12'hACE,
  parameter int          H_ACTIVE      = 640,
  parameter int          V_ACTIVE      = 480
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [11:0] code,
  input  logic        h_sync_in,
  input  logic        v_sync_in,
  input  logic [3:0]  r_in,
  input  logic [3:0]  g_in,
  input  logic [3:0]  b_in,
  output logic        frame_pulse,
  output logic        locked,
  output logic        de_out,
  output logic [9:0]  x_out,
  output logic [9:0]  y_out,
  output logic [3:0]  r_out,
  output logic [3:0]  g_out,
  output logic [3:0]  b_out
);

  typedef enum logic [1:0] {SEARCH = 2'd0, CHECK = 2'd1, LOCKED = 2'd2} state_t;

  localparam logic [9:0] H_LAST  = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST  = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_LO    = 10'(H_ACT_START);
  localparam logic [9:0] H_HI    = 10'(H_ACT_START + H_ACTIVE);
  localparam logic [9:0] V_LO    = 10'(V_ACT_START);
  localparam logic [9:0] V_HI    = 10'(V_ACT_START + V_ACTIVE);
  localparam logic [9:0] CNT_MAX = 10'h3FF;

  logic        hs_q, hs_d, vs_q, vs_d;
  logic        hs_prev_q, hs_prev_d, vs_prev_q, vs_prev_d;
  logic [11:0] rgb_q, rgb_d;
  logic [9:0]  h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
  logic        bad_q, bad_d;
  logic [11:0] lfsr_q, lfsr_d;
  state_t      state_q, state_d;
  logic        frame_pulse_q, frame_pulse_d, locked_q, locked_d, de_q, de_d;
  logic [9:0]  x_q, x_d, y_q, y_d;
  logic [11:0] pix_q, pix_d;
  logic        hs_fall, vs_fall, active, line_ok, frame_ok, lfsr_fb;

  always_comb begin
    hs_d      = h_sync_in;
    vs_d      = v_sync_in;
    rgb_d     = {r_in, g_in, b_in};
    hs_prev_d = hs_q;
    vs_prev_d = vs_q;
  end

  // Counters hold the position of the pixel currently in the input stage; a sync edge makes that pixel position 0.
  always_comb begin
    hs_fall  = hs_prev_q & ~hs_q;
    vs_fall  = vs_prev_q & ~vs_q;
    h_cnt_d  = hs_fall ? 10'd0 : ((h_cnt_q == CNT_MAX) ? h_cnt_q : h_cnt_q + 10'd1);
    v_cnt_d  = v_cnt_q;
    if (vs_fall)
      v_cnt_d = 10'd0;
    else if (hs_fall && (v_cnt_q != CNT_MAX))
      v_cnt_d = v_cnt_q + 10'd1;
    active   = (h_cnt_d >= H_LO) && (h_cnt_d < H_HI) && (v_cnt_d >= V_LO) && (v_cnt_d < V_HI);
    line_ok  = (h_cnt_q == H_LAST);
    frame_ok = !bad_q && hs_fall && line_ok && (v_cnt_q == V_LAST);
    bad_d    = bad_q;
    if (vs_fall)
      bad_d = 1'b0;
    else if (hs_fall && !line_ok)
      bad_d = 1'b1;
    lfsr_fb  = lfsr_q[11] ^ lfsr_q[10] ^ lfsr_q[9] ^ lfsr_q[3];
    lfsr_d   = lfsr_q;
    if (vs_fall)
      lfsr_d = (code == 12'd0) ? KEY_ZERO_SEED : code;
    else if (active)
      lfsr_d = {lfsr_q[10:0], lfsr_fb};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hs_q      <= 1'b1;
      vs_q      <= 1'b1;
      hs_prev_q <= 1'b1;
      vs_prev_q <= 1'b1;
      rgb_q     <= '0;
      h_cnt_q   <= '0;
      v_cnt_q   <= '0;
      bad_q     <= 1'b0;
      lfsr_q    <= KEY_ZERO_SEED;
    end else begin
      hs_q      <= hs_d;
      vs_q      <= vs_d;
      hs_prev_q <= hs_prev_d;
      vs_prev_q <= vs_prev_d;
      rgb_q     <= rgb_d;
      h_cnt_q   <= h_cnt_d;
      v_cnt_q   <= v_cnt_d;
      bad_q     <= bad_d;
      lfsr_q    <= lfsr_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state_q <= SEARCH;
    else
      state_q <= state_d;
  end

  // A short line or an overlong frame drops lock at once; lock is only granted after one fully clean frame.
  always_comb begin
    state_d = state_q;
    case (state_q)
      SEARCH:  if (vs_fall) state_d = CHECK;
      CHECK:   if (vs_fall && frame_ok) state_d = LOCKED;
      LOCKED:  if (hs_fall && (!line_ok || (!vs_fall && (v_cnt_q == V_LAST)))) state_d = SEARCH;
      default: state_d = SEARCH;
    endcase
  end

  always_comb begin
    locked_d      = (state_d == LOCKED);
    de_d          = active && locked_d;
    frame_pulse_d = vs_fall;
    x_d           = de_d ? (h_cnt_d - H_LO) : 10'd0;
    y_d           = de_d ? (v_cnt_d - V_LO) : 10'd0;
    pix_d         = de_d ? (rgb_q ^ lfsr_q) : 12'd0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_pulse_q <= 1'b0;
      locked_q      <= 1'b0;
      de_q          <= 1'b0;
      x_q           <= '0;
      y_q           <= '0;
      pix_q         <= '0;
    end else begin
      frame_pulse_q <= frame_pulse_d;
      locked_q      <= locked_d;
      de_q          <= de_d;
      x_q           <= x_d;
      y_q           <= y_d;
      pix_q         <= pix_d;
    end
  end

  assign frame_pulse = frame_pulse_q;
  assign locked      = locked_q;
  assign de_out      = de_q;
  assign x_out       = x_q;
  assign y_out       = y_q;
  assign r_out       = pix_q[11:8];
  assign g_out       = pix_q[7:4];
  assign b_out       = pix_q[3:0];

endmodule

// File: tb/tb_vga_slave_rx.sv
// Bench for vga_slave_rx on a shrunken 40x20 raster: a frame/line-level reference model predicts
// every output cycle, plus directed checks on lock, first-pixel keys and reset behaviour.
module tb_vga_slave_rx;

  localparam int HT   = 40;
  localparam int VT   = 20;
  localparam int HAS  = 8;
  localparam int VAS  = 3;
  localparam int HACT = 24;
  localparam int VACT = 12;
  localparam int HSW  = 4;
  localparam int VSW  = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [11:0] code = 12'd0;
  logic        h_sync_in = 1'b1, v_sync_in = 1'b1;
  logic [3:0]  r_in = '0, g_in = '0, b_in = '0;
  logic        frame_pulse, locked, de_out;
  logic [9:0]  x_out, y_out;
  logic [3:0]  r_out, g_out, b_out;

  typedef struct packed {
    logic        fp;
    logic        lk;
    logic        de;
    logic [9:0]  x;
    logic [9:0]  y;
    logic [11:0] rgb;
    logic [11:0] raw;
    logic        chk;
    logic [11:0] dk;
  } exp_t;

  exp_t        expQ[$];
  int          testsRun = 0;
  int          failCount = 0;
  int          mState = 0;
  int          prevLen = 0;
  int          prevLines = 0;
  int          rstHold = 0;
  bit          frameClean = 1'b0;
  logic [11:0] mKey = 12'hACE;
  bit          dirArm = 1'b0;
  logic [11:0] dirKey0 = 12'd0, dirKey1 = 12'd0;

  vga_slave_rx #(
    .H_TOTAL(HT), .V_TOTAL(VT), .H_ACT_START(HAS), .V_ACT_START(VAS),
    .KEY_ZERO_SEED(12'hACE), .H_ACTIVE(HACT), .V_ACTIVE(VACT)
  ) dut (
    .clk(clk), .reset(reset), .code(code),
    .h_sync_in(h_sync_in), .v_sync_in(v_sync_in),
    .r_in(r_in), .g_in(g_in), .b_in(b_in),
    .frame_pulse(frame_pulse), .locked(locked), .de_out(de_out),
    .x_out(x_out), .y_out(y_out),
    .r_out(r_out), .g_out(g_out), .b_out(b_out)
  );

  always #5 clk = ~clk;

  function automatic logic [11:0] keyStep(input logic [11:0] k);
    return {k[10:0], ^(k & 12'hE08)};
  endfunction

  // Reference model: lock decided per line/frame from the generated geometry, keystream per active pixel.
  task modelPixel(input int line, input int col, input logic [11:0] rgb, output exp_t e);
    bit act;
    e = '0;
    e.raw = rgb;
    if (col == 0 && line == 0) begin
      e.fp = 1'b1;
      if (mState == 0)
        mState = 1;
      else if (mState == 1) begin
        if (frameClean && prevLen == HT && prevLines == VT) mState = 2;
      end else if (prevLen != HT)
        mState = 0;
      frameClean = 1'b1;
      mKey = (code == 12'd0) ? 12'hACE : code;
    end else if (col == 0) begin
      if (prevLen != HT) begin
        frameClean = 1'b0;
        if (mState == 2) mState = 0;
      end
      if (line == VT && mState == 2) mState = 0;
    end
    act = (col >= HAS) && (col < HAS + HACT) && (line >= VAS) && (line < VAS + VACT);
    e.lk = (mState == 2);
    if (act) begin
      if (e.lk) begin
        e.de  = 1'b1;
        e.x   = 10'(col - HAS);
        e.y   = 10'(line - VAS);
        e.rgb = rgb ^ mKey;
        if (dirArm && line == VAS && col == HAS)     begin e.chk = 1'b1; e.dk = dirKey0; end
        if (dirArm && line == VAS && col == HAS + 1) begin e.chk = 1'b1; e.dk = dirKey1; end
      end
      mKey = keyStep(mKey);
    end
  endtask

  task checkOutput();
    exp_t e;
    if (expQ.size() >= 2) begin
      e = expQ.pop_front();
      testsRun++;
      assert ({frame_pulse, locked, de_out} === {e.fp, e.lk, e.de}) else begin
        failCount++;
        $error("FAIL ctrl fp/lk/de observed=%b%b%b expected=%b%b%b", frame_pulse, locked, de_out, e.fp, e.lk, e.de);
      end
      testsRun++;
      assert ({x_out, y_out, r_out, g_out, b_out} === {e.x, e.y, e.rgb}) else begin
        failCount++;
        $error("FAIL data x/y/rgb observed=%0d/%0d/%h expected=%0d/%0d/%h", x_out, y_out, {r_out, g_out, b_out}, e.x, e.y, e.rgb);
      end
      if (e.chk) begin
        testsRun++;
        assert ({r_out, g_out, b_out} === (e.raw ^ e.dk)) else begin
          failCount++;
          $error("FAIL first_key rgb observed=%h expected=%h", {r_out, g_out, b_out}, e.raw ^ e.dk);
        end
      end
    end
  endtask

  task applyStimulus(input logic hs, input logic vs, input logic [11:0] rgb, input exp_t e, input logic rel);
    @(posedge clk);
    #1;
    checkOutput();
    if (rel) reset = 1'b0;
    h_sync_in = hs;
    v_sync_in = vs;
    {r_in, g_in, b_in} = rgb;
    expQ.push_back(e);
  endtask

  task checkZeros(input string tag);
    testsRun++;
    assert (frame_pulse === 1'b0) else begin failCount++; $error("FAIL %s_fp observed=%b expected=0", tag, frame_pulse); end
    testsRun++;
    assert (locked === 1'b0) else begin failCount++; $error("FAIL %s_locked observed=%b expected=0", tag, locked); end
    testsRun++;
    assert (de_out === 1'b0) else begin failCount++; $error("FAIL %s_de observed=%b expected=0", tag, de_out); end
    testsRun++;
    assert ({x_out, y_out, r_out, g_out, b_out} === 32'd0) else begin
      failCount++;
      $error("FAIL %s_data observed=%h expected=0", tag, {x_out, y_out, r_out, g_out, b_out});
    end
  endtask

  task checkLocked(input string tag, input logic want);
    testsRun++;
    assert (locked === want) else begin failCount++; $error("FAIL %s observed=%b expected=%b", tag, locked, want); end
  endtask

  task doMidReset();
    reset = 1'b1;
    #1;
    checkZeros("midrst");
    expQ.delete();
    expQ.push_back('0);
    expQ.push_back('0);
    mState  = 0;
    mKey    = 12'hACE;
    rstHold = 3;
  endtask

  task sendFrame(input logic [11:0] fcode, input int nLines, input int shortLine,
                 input int changeLine, input logic [11:0] newCode, input int rstLine, input int rstCol);
    exp_t        e;
    logic [11:0] rgb;
    logic        rel;
    int          len;
    code = fcode;
    for (int line = 0; line < nLines; line++) begin
      len = (line == shortLine) ? HT - 1 : HT;
      if (line == changeLine) code = newCode;
      for (int col = 0; col < len; col++) begin
        if (line == rstLine && col == rstCol) doMidReset();
        rgb = 12'($urandom);
        if (rstHold > 0) begin
          e = '0;
          rstHold--;
          rel = 1'b0;
        end else begin
          rel = reset;
          modelPixel(line, col, rgb, e);
        end
        applyStimulus(col >= HSW, line >= VSW, rgb, e, rel);
      end
      prevLen = len;
    end
    prevLines = nLines;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    checkZeros("reset");
    expQ.push_back('0);
    expQ.push_back('0);
    reset = 1'b0;

    sendFrame(12'h0F3, VT, -1, -1, 12'd0, -1, -1);
    dirKey0 = 12'h0F3;
    dirKey1 = 12'h1E6;
    dirArm  = 1'b1;
    sendFrame(12'h0F3, VT, -1, -1, 12'd0, -1, -1);
    checkLocked("lock_after_2nd_vsync", 1'b1);
    dirKey0 = 12'hACE;
    dirKey1 = 12'h59D;
    sendFrame(12'h000, VT, -1, -1, 12'd0, -1, -1);
    dirArm = 1'b0;
    sendFrame(12'($urandom_range(1, 4095)), VT, -1, 8, 12'($urandom_range(1, 4095)), -1, -1);
    sendFrame(12'($urandom_range(0, 4095)), VT, 8, -1, 12'd0, -1, -1);
    checkLocked("drop_short_line", 1'b0);
    sendFrame(12'($urandom_range(0, 4095)), VT, -1, -1, 12'd0, -1, -1);
    checkLocked("still_checking", 1'b0);
    sendFrame(12'($urandom_range(0, 4095)), VT, -1, -1, 12'd0, -1, -1);
    checkLocked("relock_short", 1'b1);
    sendFrame(12'($urandom_range(0, 4095)), VT, -1, -1, 12'd0, 9, 20);
    checkLocked("lost_after_reset", 1'b0);
    sendFrame(12'($urandom_range(0, 4095)), VT, -1, -1, 12'd0, -1, -1);
    checkLocked("check_after_reset", 1'b0);
    sendFrame(12'h0F3, VT, -1, -1, 12'd0, -1, -1);
    checkLocked("relock_reset", 1'b1);
    sendFrame(12'h0F3, 1, -1, -1, 12'd0, -1, -1);

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule

// File: doc/vga_slave_rx.md
VGA_SLAVE_RX -- requirements
Module: vga_slave_rx

Interface
REQ-001 SHALL have parameter H_TOTAL, default 800, meaning pixel clocks per line.
REQ-002 SHALL have parameter V_TOTAL, default 525, meaning lines per frame.
REQ-003 SHALL have parameter H_ACT_START, default 144, meaning first active h_cnt (sync 96 + back porch 48).
REQ-004 SHALL have parameter V_ACT_START, default 35, meaning first active v_cnt (sync 2 + back porch 33).
REQ-005 SHALL have parameter KEY_ZERO_SEED, default 12'hACE, meaning LFSR seed used when code is 0.
REQ-006 clk  input  1  pixel clock of the received stream; reset asynchronous, active-high (reset  input  1).
REQ-007 code  input  12  descramble key, sampled only at frame start.
REQ-008 h_sync_in, v_sync_in  input  1 each  received syncs, active-low.
REQ-009 r_in, g_in, b_in  input  4 each  scrambled pixel data.
REQ-010 frame_pulse  output  1  one-cycle pulse at each v_sync_in falling edge (returned to master as rising_edge).
REQ-011 locked  output  1  stream timing validated.
REQ-012 de_out  output  1; x_out  output  10; y_out  output  10; r_out, g_out, b_out  output  4 each  descrambled pixel and position.

Function
REQ-013 SHALL register h_sync_in, v_sync_in, RGB in one input stage; all edge detection uses registered values.
REQ-014 h_cnt (10 bit) SHALL load 0 on the cycle a registered h_sync falling edge is seen, else increment, saturating at 1023.
REQ-015 v_cnt (10 bit) SHALL load 0 on registered v_sync falling edge, else increment on each h_sync falling edge, saturating at 1023; v_sync edge wins if simultaneous with h_sync edge.
REQ-016 Pixel active when H_ACT_START <= h_cnt < H_ACT_START+640 and V_ACT_START <= v_cnt < V_ACT_START+480.
REQ-017 Lock FSM states: SEARCH, CHECK, LOCKED.
REQ-018 SEARCH -> CHECK on first v_sync falling edge.
REQ-019 CHECK -> LOCKED at next v_sync falling edge if every line of that frame had exactly H_TOTAL clocks and the frame had exactly V_TOTAL lines; else stays CHECK (restart check).
REQ-020 LOCKED -> SEARCH immediately on any line length != H_TOTAL or line count reaching V_TOTAL without v_sync edge; locked=1 only in LOCKED.
REQ-021 Keystream: 12-bit Fibonacci LFSR, taps 12,11,10,4 (feedback XOR into bit 0, shift left).
REQ-022 At each v_sync falling edge LFSR SHALL load code, or KEY_ZERO_SEED if code==0.
REQ-023 LFSR SHALL advance once per active pixel only; blanking leaves it unchanged.
REQ-024 {r_out,g_out,b_out} = {r_in,g_in,b_in} XOR current LFSR value, for the pixel at which it is applied.
REQ-025 x_out = h_cnt-H_ACT_START, y_out = v_cnt-V_ACT_START during active pixels; 0 otherwise.
REQ-026 de_out = active AND locked; when de_out=0, RGB outputs and x/y SHALL be 0.
REQ-027 Latency: pixel present on inputs at cycle N appears on outputs at cycle N+2, all outputs registered.
REQ-028 frame_pulse asserts in the same output cycle as the v_cnt reload, independent of lock state.

Reset
REQ-029 Reset SHALL clear all counters, LFSR to KEY_ZERO_SEED, FSM to SEARCH, all outputs 0, synchronizer registers to 1 (idle syncs).
REQ-030 Reset mid-frame SHALL discard lock; locking requires a fresh SEARCH->CHECK->LOCKED sequence (minimum two full frames).

Verification
REQ-031 Ideal 800x525 stream, code=12'h0F3 -> locked=1 after the second v_sync falling edge; first active pixel x=0,y=0 with RGB = in XOR 12'h0F3.
REQ-032 code=0 -> first active pixel RGB XOR 12'hACE; second pixel XOR the LFSR's next value (one shift).
REQ-033 One line of 799 clocks while LOCKED -> locked drops on that h_sync edge, de_out=0 until two clean frames relock.
REQ-034 code changed mid-frame -> keystream unchanged until next v_sync falling edge, then reseeded.
REQ-035 Reset asserted at x=300,y=200 -> all outputs 0 within reset, locked=0, frame_pulse on next v_sync edge.
REQ-036 Blanking-region pixel inputs nonzero -> outputs remain 0, LFSR value unchanged across blanking.
